// File: rtl/ipm2l_fifo_pkg.sv
// Shared helpers for the multi-channel FIFO controller: width math and flattened-bus slicing.
package ipm2l_fifo_pkg;

  function automatic int clog2(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return w;
  endfunction

  // Pointers carry one extra MSB so full and empty stay distinguishable.
  function automatic int ptr_width(input int depth_width);
    return depth_width + 1;
  endfunction

  // Level spans 0..2^D, so it needs one bit more than the address.
  function automatic int lvl_width(input int depth_width);
    return depth_width + 1;
  endfunction

  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/ipm2l_fifo_chan_ptr.sv
// One logical FIFO channel: read/write pointers, level, flags and sticky error bits.
// Error bits exist only when FIFO_CTRL_ERR_CNT_EN is defined; otherwise they are tied low.
module ipm2l_fifo_chan_ptr
  import ipm2l_fifo_pkg::*;
#(
  parameter  int D  = 9,
  parameter  int AF = 508,
  parameter  int AE = 4,
  localparam int PW = ptr_width(D),
  localparam int LW = lvl_width(D)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_inc,
  input  logic          rd_inc,
  input  logic          flush,
`ifdef FIFO_CTRL_ERR_CNT_EN
  input  logic          ovf_evt,
  input  logic          unf_evt,
`endif
  output logic [D-1:0]  wlo,
  output logic [D-1:0]  rlo,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic          overflow,
  output logic          underflow
);

  localparam logic [LW-1:0] FULL_LVL = LW'(1) << D;

  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          full_q, empty_q, afull_q, aempty_q;

  always_comb begin
    wptr_d = wptr_q + PW'(wr_inc);
    rptr_d = rptr_q + PW'(rd_inc);
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
    end
    level_d = LW'(wptr_d - rptr_d);
  end

  // Flags come from next-state pointers so they move on the same edge as the pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      level_q  <= level_d;
      full_q   <= (level_d == FULL_LVL);
      empty_q  <= (level_d == '0);
      afull_q  <= (level_d >= LW'(AF));
      aempty_q <= (level_d <= LW'(AE));
    end
  end

`ifdef FIFO_CTRL_ERR_CNT_EN
  logic ovf_q, unf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (flush) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (ovf_evt) ovf_q <= 1'b1;
      if (unf_evt) unf_q <= 1'b1;
    end
  end

  assign overflow  = ovf_q;
  assign underflow = unf_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

  assign wlo          = wptr_q[D-1:0];
  assign rlo          = rptr_q[D-1:0];
  assign level        = level_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;

endmodule

// File: rtl/ipm2l_fifo_ctrl_mc.sv
// Multi-channel FIFO controller over one shared RAM addressed as {channel, pointer}.
// Optional sticky overflow/underflow bits are enabled by defining FIFO_CTRL_ERR_CNT_EN.
module ipm2l_fifo_ctrl_mc
  import ipm2l_fifo_pkg::*;
#(
  parameter  int C_CHANNELS         = 4,
  parameter  int C_DEPTH_WIDTH      = 9,
  parameter  int C_ALMOST_FULL_NUM  = 508,
  parameter  int C_ALMOST_EMPTY_NUM = 4,
  localparam int C_CH_WIDTH         = clog2(C_CHANNELS),
  localparam int LW                 = lvl_width(C_DEPTH_WIDTH)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                w_en,
  input  logic [C_CH_WIDTH-1:0]               w_ch,
  output logic                                w_accept,
  output logic [C_CH_WIDTH+C_DEPTH_WIDTH-1:0] waddr,
  input  logic                                r_en,
  input  logic [C_CH_WIDTH-1:0]               r_ch,
  output logic                                r_accept,
  output logic [C_CH_WIDTH+C_DEPTH_WIDTH-1:0] raddr,
  input  logic [C_CHANNELS-1:0]               flush,
  output logic [C_CHANNELS-1:0]               wfull,
  output logic [C_CHANNELS-1:0]               rempty,
  output logic [C_CHANNELS-1:0]               almost_full,
  output logic [C_CHANNELS-1:0]               almost_empty,
  output logic [C_CHANNELS*LW-1:0]            water_level,
  output logic [C_CHANNELS-1:0]               overflow,
  output logic [C_CHANNELS-1:0]               underflow
);

  logic [C_CHANNELS-1:0]    w_hit, r_hit, wr_inc, rd_inc;
  logic [C_DEPTH_WIDTH-1:0] wlo [C_CHANNELS];
  logic [C_DEPTH_WIDTH-1:0] rlo [C_CHANNELS];
  logic [C_DEPTH_WIDTH-1:0] wlo_sel, rlo_sel;

  // An out-of-range select matches no channel, so it is rejected and changes nothing.
  for (genvar k = 0; k < C_CHANNELS; k++) begin : g_ch
    localparam int LO = slice_lo(k, LW);

    assign w_hit[k]  = w_en && (w_ch == C_CH_WIDTH'(k));
    assign r_hit[k]  = r_en && (r_ch == C_CH_WIDTH'(k));
    assign wr_inc[k] = w_hit[k] & ~wfull[k]  & ~flush[k];
    assign rd_inc[k] = r_hit[k] & ~rempty[k] & ~flush[k];

    ipm2l_fifo_chan_ptr #(
      .D  (C_DEPTH_WIDTH),
      .AF (C_ALMOST_FULL_NUM),
      .AE (C_ALMOST_EMPTY_NUM)
    ) u_chan (
      .clk          (clk),
      .rst_n        (rst_n),
      .wr_inc       (wr_inc[k]),
      .rd_inc       (rd_inc[k]),
      .flush        (flush[k]),
`ifdef FIFO_CTRL_ERR_CNT_EN
      .ovf_evt      (w_hit[k] & wfull[k]),
      .unf_evt      (r_hit[k] & rempty[k]),
`endif
      .wlo          (wlo[k]),
      .rlo          (rlo[k]),
      .level        (water_level[LO +: LW]),
      .full         (wfull[k]),
      .empty        (rempty[k]),
      .almost_full  (almost_full[k]),
      .almost_empty (almost_empty[k]),
      .overflow     (overflow[k]),
      .underflow    (underflow[k])
    );
  end

  always_comb begin
    wlo_sel = '0;
    rlo_sel = '0;
    for (int k = 0; k < C_CHANNELS; k++) begin
      if (w_ch == C_CH_WIDTH'(k)) wlo_sel = wlo[k];
      if (r_ch == C_CH_WIDTH'(k)) rlo_sel = rlo[k];
    end
  end

  assign w_accept = |wr_inc;
  assign r_accept = |rd_inc;
  assign waddr    = {w_ch, wlo_sel};
  assign raddr    = {r_ch, rlo_sel};

endmodule

// File: tb/tb_ipm2l_fifo_ctrl_mc.sv
// Self-checking bench for ipm2l_fifo_ctrl_mc: count-based reference model plus directed vectors.
module tb_ipm2l_fifo_ctrl_mc;

  localparam int NCH = 4;
  localparam int DW  = 4;
  localparam int DEP = 16;
  localparam int AF  = 14;
  localparam int AE  = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       w_en, r_en;
  logic [1:0] w_ch, r_ch;
  logic       w_accept, r_accept;
  logic [5:0] waddr, raddr;
  logic [3:0] flush, wfull, rempty, almost_full, almost_empty, overflow, underflow;
  logic [19:0] water_level;

  int checks = 0;
  int errors = 0;

  // Model: total accepted writes/reads per channel since last clear.
  int wcnt [NCH];
  int rcnt [NCH];
  bit ovf_m [NCH];
  bit unf_m [NCH];

  ipm2l_fifo_ctrl_mc #(
    .C_CHANNELS(NCH), .C_DEPTH_WIDTH(DW),
    .C_ALMOST_FULL_NUM(AF), .C_ALMOST_EMPTY_NUM(AE)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .w_en(w_en), .w_ch(w_ch), .w_accept(w_accept), .waddr(waddr),
    .r_en(r_en), .r_ch(r_ch), .r_accept(r_accept), .raddr(raddr),
    .flush(flush), .wfull(wfull), .rempty(rempty),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .water_level(water_level), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  function automatic int lvl(input int k);
    return wcnt[k] - rcnt[k];
  endfunction

  function automatic int wl(input int k);
    return int'((water_level >> (k * 5)) & 20'h1F);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NCH; k++) begin
        wcnt[k]  <= 0;
        rcnt[k]  <= 0;
        ovf_m[k] <= 1'b0;
        unf_m[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (flush[k]) begin
          wcnt[k]  <= 0;
          rcnt[k]  <= 0;
          ovf_m[k] <= 1'b0;
          unf_m[k] <= 1'b0;
        end else begin
          if (w_en && w_ch == 2'(k) && lvl(k) < DEP) wcnt[k] <= wcnt[k] + 1;
          if (r_en && r_ch == 2'(k) && lvl(k) > 0)   rcnt[k] <= rcnt[k] + 1;
`ifdef FIFO_CTRL_ERR_CNT_EN
          if (w_en && w_ch == 2'(k) && lvl(k) == DEP) ovf_m[k] <= 1'b1;
          if (r_en && r_ch == 2'(k) && lvl(k) == 0)   unf_m[k] <= 1'b1;
`endif
        end
      end
    end
  end

  // Compare process: every outputs is checked against the model on each falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      int wc, rc;
      wc = int'(w_ch);
      rc = int'(r_ch);
      chk("w_accept", int'(w_accept), int'(w_en && lvl(wc) < DEP && !flush[wc]));
      chk("r_accept", int'(r_accept), int'(r_en && lvl(rc) > 0 && !flush[rc]));
      chk("waddr", int'(waddr), wc * DEP + (wcnt[wc] % DEP));
      chk("raddr", int'(raddr), rc * DEP + (rcnt[rc] % DEP));
      for (int k = 0; k < NCH; k++) begin
        chk("level", wl(k), lvl(k));
        chk("wfull", int'(wfull[k]), int'(lvl(k) == DEP));
        chk("rempty", int'(rempty[k]), int'(lvl(k) == 0));
        chk("almost_full", int'(almost_full[k]), int'(lvl(k) >= AF));
        chk("almost_empty", int'(almost_empty[k]), int'(lvl(k) <= AE));
        chk("overflow", int'(overflow[k]), int'(ovf_m[k]));
        chk("underflow", int'(underflow[k]), int'(unf_m[k]));
      end
    end
  end

  task automatic drive(input bit we, input int wc, input bit re, input int rc, input logic [3:0] fl);
    w_en  = we;
    w_ch  = 2'(wc);
    r_en  = re;
    r_ch  = 2'(rc);
    flush = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 4'h0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    tick();
    chk("reset_rempty", int'(rempty), 15);
    chk("reset_aempty", int'(almost_empty), 15);
    chk("reset_level", int'(water_level), 0);
    chk("reset_wfull", int'(wfull), 0);
    chk("idle_w_accept", int'(w_accept), 0);

    // Fill channel 1
    for (int i = 0; i < 16; i++) begin
      drive(1, 1, 0, 0, 4'h0);
      chk("fill_waddr", int'(waddr), 16 + i);
      chk("fill_accept", int'(w_accept), 1);
      tick();
      if (i == 12) chk("af_before14", int'(almost_full[1]), 0);
      if (i == 13) chk("af_at14", int'(almost_full[1]), 1);
    end
    chk("full_flag", int'(wfull), 4'b0010);
    chk("full_level", wl(1), 16);
    drive(1, 1, 0, 0, 4'h0);
    chk("write17_reject", int'(w_accept), 0);
    tick();
    chk("others_empty", int'(rempty), 4'b1101);
`ifdef FIFO_CTRL_ERR_CNT_EN
    chk("overflow1", int'(overflow[1]), 1);
`else
    chk("overflow_off", int'(overflow), 0);
`endif

    // Read and write at full, then simultaneous at 15
    drive(1, 1, 1, 1, 4'h0);
    chk("full_rw_w", int'(w_accept), 0);
    chk("full_rw_r", int'(r_accept), 1);
    tick();
    chk("level_15", wl(1), 15);
    drive(1, 1, 1, 1, 4'h0);
    chk("rw15_w", int'(w_accept), 1);
    tick();
    chk("level_stays15", wl(1), 15);

    // Preload ch2, then write ch0 while reading ch2
    for (int i = 0; i < 3; i++) begin
      drive(1, 2, 0, 0, 4'h0);
      tick();
    end
    drive(1, 0, 1, 2, 4'h0);
    chk("ilv_waddr", int'(waddr), 6'h00);
    chk("ilv_raddr", int'(raddr), 6'h20);
    tick();
    chk("ilv_ch0", wl(0), 1);
    chk("ilv_ch2", wl(2), 2);
    chk("ilv_ae2", int'(almost_empty[2]), 1);

    // Drain ch0 and read once more while empty
    drive(0, 0, 1, 0, 4'h0);
    tick();
    drive(0, 0, 1, 0, 4'h0);
    chk("empty_read_reject", int'(r_accept), 0);
    tick();

    // Wrap ch3 with paired write/read
    for (int i = 0; i < 40; i++) begin
      drive(1, 3, 1, 3, 4'h0);
      tick();
      chk("wrap_le1", int'(wl(3) <= 1), 1);
    end
    chk("wrap_level", wl(3), 1);
    chk("wrap_raddr", int'(raddr), 6'h37);
    drive(0, 0, 1, 3, 4'h0);
    tick();
    chk("wrap_empty", int'(rempty[3]), 1);

    // Bring ch1 to level 9, then flush with a colliding write
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, 1, 1, 4'h0);
      tick();
    end
    chk("pre_flush_level", wl(1), 9);
    drive(1, 1, 0, 0, 4'b0010);
    chk("flush_w_reject", int'(w_accept), 0);
    tick();
    drive(0, 0, 0, 0, 4'h0);
    chk("flush_level", wl(1), 0);
    chk("flush_empty", int'(rempty[1]), 1);
    chk("flush_ovf", int'(overflow[1]), 0);
    chk("flush_others", wl(2), 2);

    // Mid-operation reset pulse
    drive(1, 0, 0, 0, 4'h0);
    tick();
    tick();
    drive(0, 0, 0, 0, 4'h0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_rempty", int'(rempty), 15);
    chk("rst_level", int'(water_level), 0);
    chk("rst_aempty", int'(almost_empty), 15);
    chk("rst_err", int'(overflow | underflow), 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    drive(1, 2, 0, 0, 4'h0);
    chk("post_rst_waddr", int'(waddr), 6'h20);
    tick();
    drive(0, 0, 0, 0, 4'h0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ipm2l_fifo_ctrl_mc.md
Name: ipm2l_fifo_ctrl_mc

Overview:
Single-clock, multi-channel FIFO controller and successor to the single-channel async/sync FIFO pointer controller. It manages C_CHANNELS independent logical FIFOs, each 2^C_DEPTH_WIDTH deep, carved from one shared simple-dual-port RAM addressed as {channel, pointer}. It provides per-channel full/empty, almost flags, water levels and a per-channel flush. It sits between DMA channel logic and one shared block-RAM instance.

Parameters:
C_CHANNELS, 4, number of logical FIFOs (2..16)
C_DEPTH_WIDTH, 9, log2 of per-channel depth
C_ALMOST_FULL_NUM, 508, almost_full asserted when level >= this
C_ALMOST_EMPTY_NUM, 4, almost_empty asserted when level <= this
C_CH_WIDTH, derived clog2(C_CHANNELS), channel index width; not user-set

Ports:
clk  in  1  single clock
rst_n  in  1  asynchronous active-low reset
w_en  in  1  write request
w_ch  in  C_CH_WIDTH  write channel select
w_accept  out  1  RAM write enable, combinational
waddr  out  C_CH_WIDTH+C_DEPTH_WIDTH  RAM write address {w_ch, wptr[w_ch]}
r_en  in  1  read request
r_ch  in  C_CH_WIDTH  read channel select
r_accept  out  1  RAM read enable, combinational
raddr  out  C_CH_WIDTH+C_DEPTH_WIDTH  RAM read address {r_ch, rptr[r_ch]}
flush  in  C_CHANNELS  per-channel synchronous clear
wfull  out  C_CHANNELS  registered full flags
rempty  out  C_CHANNELS  registered empty flags
almost_full  out  C_CHANNELS  registered
almost_empty  out  C_CHANNELS  registered
water_level  out  C_CHANNELS*(C_DEPTH_WIDTH+1)  flattened; channel k at [k*(D+1) +: D+1]
overflow  out  C_CHANNELS  sticky error (optional feature)
underflow  out  C_CHANNELS  sticky error (optional feature)

Behaviour:
- Reset (rst_n low, async): all pointers 0; rempty=all 1; almost_empty=all 1; wfull=0; almost_full=0; water_level=0; overflow/underflow=0.
- Per-channel pointers wptr/rptr are C_DEPTH_WIDTH+1 bits, binary, and wrap modulo 2^(D+1). level = wptr - rptr, mod 2^(D+1), range 0..2^D.
- w_accept = w_en & (w_ch < C_CHANNELS) & ~wfull[w_ch] & ~flush[w_ch].
- r_accept = r_en & (r_ch < C_CHANNELS) & ~rempty[r_ch] & ~flush[r_ch].
- waddr and raddr use the current (pre-increment) pointer low bits. The accepted pointer increments on the next clk edge.
- All flags and the water level are registered from next-state pointers. They update on the same edge as the pointers, with zero extra latency.
- Flag definitions: full is level==2^D; empty is level==0; almost flags compare level to the parameters.
- Simultaneous accepted write and read on the same channel: both pointers advance and the level is unchanged. This is legal even when full, because rempty=0 there, but the write is still rejected while wfull=1.
- Different channels may be written and read in the same cycle independently.
- Flush on channel k: wptr=rptr=0 on that edge, and rempty[k]=1 next cycle. Flush overrides any same-cycle access on k. Other channels are unaffected.
- Out-of-range channel select: access rejected; no state changes.
- Pointer wrap: the low bits roll 2^D-1 -> 0 and the MSB toggles. Level arithmetic stays correct across the wrap.

Optional Feature:
FIFO_CTRL_ERR_CNT_EN
- Defined: overflow[k] sets when w_en targets k while wfull[k]. underflow[k] sets when r_en targets k while rempty[k]. Both are sticky until flush[k] or reset.
- Undefined: overflow and underflow are tied 0 and no registers are inferred.

Decomposition:
- Shared package ipm2l_fifo_pkg holds:
  - clog2 function;
  - pointer-width and level-width constants;
  - flattened-bus slice helper.
- Sub-module ipm2l_fifo_chan_ptr holds one channel's pointers, level, flags and error bits, with inputs wr_inc, rd_inc and flush.
- The top instantiates C_CHANNELS copies in a generate loop and does the channel-select muxing.

Test Plan (C_CHANNELS=4, C_DEPTH_WIDTH=4, AF=14, AE=2):
- Reset, then idle -> rempty=4'b1111, almost_empty=4'b1111, water_level all 0, w_accept=0.
- 16 writes to ch1:
  - waddr 0x10..0x1F;
  - almost_full[1] asserts the edge after write 14;
  - wfull[1]=1 after write 16;
  - 17th write gives w_accept=0 (overflow[1]=1 if the macro is defined);
  - other channels remain empty.
- Read ch1 while writing ch1 at full -> write rejected, read accepted; level 15 next cycle. Then simultaneous read+write at level 15 -> level stays 15.
- Interleave writes to ch0 and reads from ch2 (ch2 preloaded with 3) -> ch0 level 1, ch2 level 2, almost_empty[2]=1. Both addresses use the correct channel prefix.
- 40 write/read pairs on ch3 -> wrap across 16 and 32 with level never exceeding 1, empty correct; raddr low bits wrap 0xF->0x0.
- Flush ch1 at level 9 with a simultaneous write to ch1 -> write rejected; level 0 and rempty[1]=1 next cycle; sticky error bits cleared. A mid-operation rst_n pulse returns all channels to the reset values.
